lsu_access_ctrl: RTL and testbench

//  Load/store unit sequencer between the core MEM stage and the data-memory bus.

---
 rtl/lsu_access_ctrl.sv | 107 ++++++++++
 tb/tb_lsu_access_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_access_ctrl.sv
// lsu_access_ctrl: load/store bus sequencer with byte lanes, load extension, misalign and timeout detection.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two word transfers instead of erroring.
module lsu_access_ctrl #(
  parameter int TIMEOUT_CYC = 256,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    req_fun3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic [1:0]    rsp_err,
  output logic          bus_stb,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_wsel,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_ack
);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESP} state_t;
  state_t state, state_nx;
  logic wr;
  logic [2:0] fun3;
  logic [AW-1:0] addr;
  logic [31:0] wdata, rd_lo, rd_hi, rsh, ld;
  logic [CW-1:0] cnt;
  logic [1:0] err;
  logic accept, mis_in, mis, timeout;
  logic [3:0] size_mask;
  logic [7:0] sel64;
  logic [63:0] wdata64;
  function automatic logic misaligned(input logic [1:0] f, input logic [1:0] a);
    return f[1] ? (a != 2'b00) : (f[0] & a[0]);
  endfunction
  assign accept = req_valid & req_ready;
  assign mis_in = misaligned(req_fun3[1:0], req_addr[1:0]);
  assign mis = misaligned(fun3[1:0], addr[1:0]);
  assign timeout = (cnt == CW'(TIMEOUT_CYC - 1)) & ~bus_ack;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = (mis_in & ~SPLIT) ? RESP : ACCESS;
      ACCESS:  if (bus_ack) state_nx = (SPLIT & mis) ? ACCESS2 : RESP;
               else if (timeout) state_nx = RESP;
      ACCESS2: if (bus_ack | timeout) state_nx = RESP;
      RESP:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= 1'b0;
      fun3 <= '0;
      addr <= '0;
      wdata <= '0;
      cnt <= '0;
      err <= 2'b00;
      rd_lo <= '0;
      rd_hi <= '0;
    end else if (accept) begin
      wr <= req_write;
      fun3 <= req_fun3;
      addr <= req_addr;
      wdata <= req_wdata;
      cnt <= '0;
      err <= (mis_in & ~SPLIT) ? 2'b01 : 2'b00;
    end else if (bus_stb) begin
      // ack on the final count still wins over the timeout
      if (bus_ack) begin
        cnt <= '0;
        if (state == ACCESS) rd_lo <= bus_rdata;
        else rd_hi <= bus_rdata;
      end else if (timeout) err <= 2'b10;
      else cnt <= cnt + CW'(1);
    end
  assign req_ready = state == IDLE;
  assign bus_stb = (state == ACCESS) || (state == ACCESS2);
  assign bus_we = bus_stb & wr;
  assign bus_addr = bus_stb ? {addr[AW-1:2], 2'b00} + (state == ACCESS2 ? AW'(4) : AW'(0)) : '0;
  assign size_mask = fun3[1] ? 4'b1111 : fun3[0] ? 4'b0011 : 4'b0001;
  // lanes and data as a 64-bit window; the upper word only matters for split accesses
  assign sel64 = {4'b0000, size_mask} << addr[1:0];
  assign wdata64 = {32'b0, wdata} << {addr[1:0], 3'b000};
  assign bus_wsel = bus_we ? (state == ACCESS2 ? sel64[7:4] : sel64[3:0]) : 4'b0000;
  assign bus_wdata = bus_we ? (state == ACCESS2 ? wdata64[63:32] : wdata64[31:0]) : '0;
  assign rsh = 32'({mis ? rd_hi : 32'b0, rd_lo} >> {addr[1:0], 3'b000});
  assign ld = fun3[1] ? rsh
            : fun3[0] ? {{16{~fun3[2] & rsh[15]}}, rsh[15:0]}
            : {{24{~fun3[2] & rsh[7]}}, rsh[7:0]};
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid ? err : 2'b00;
  assign rsp_rdata = (rsp_valid & ~wr & (err == 2'b00)) ? ld : '0;
endmodule

// File: tb/tb_lsu_access_ctrl.sv
// tb_lsu_access_ctrl: directed vectors against a per-byte schedule model of lsu_access_ctrl.
module tb_lsu_access_ctrl;
  localparam int TO = 8;
  localparam int AW = 32;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_write = 0, req_ready;
  logic [2:0] req_fun3 = 0;
  logic [AW-1:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic bus_stb, bus_we, bus_ack = 0;
  logic [AW-1:0] bus_addr;
  logic [3:0] bus_wsel;
  logic [31:0] bus_wdata, bus_rdata = 0;
  int total = 0, bad = 0, cyc = 0;

  lsu_access_ctrl #(.TIMEOUT_CYC(TO), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_fun3(req_fun3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wsel(bus_wsel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected schedule of the current transaction, in absolute cycle numbers
  bit chk_on = 0;
  int t_acc = -10, t_rsp = -10, n_acc = 0;
  int s_beg[2], s_end[2];
  bit acked[2];
  logic [AW-1:0] e_addr[2];
  logic [3:0] e_wsel[2];
  logic [31:0] e_wdata[2], rd[2];
  logic e_we;
  logic [31:0] e_rdata;
  logic [1:0] e_err;
  logic [AW-1:0] seen_addr[2];
  logic [3:0] seen_wsel[2];
  logic [31:0] seen_wdata[2], seen_rdata;
  logic [1:0] seen_err;
  int seen_lat, stb_cnt;
  logic nxt_w;
  logic [2:0] nxt_f;
  logic [AW-1:0] nxt_a;
  logic [31:0] nxt_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic plan(input logic w, input logic [2:0] f, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [31:0] r0, input logic [31:0] r1, input int k0, input int k1);
    int n, off, kk[2];
    bit mis;
    logic [63:0] lanes;
    logic [31:0] v;
    n = f[1] ? 4 : f[0] ? 2 : 1;
    off = int'(a[1:0]);
    mis = (off % n) != 0;
    rd[0] = r0; rd[1] = r1; kk[0] = k0; kk[1] = k1;
    e_we = w; e_err = 2'b00; e_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      e_addr[i] = {a[AW-1:2], 2'b00} + AW'(4 * i);
      e_wsel[i] = 0;
      e_wdata[i] = 0;
    end
    for (int j = 0; j < 4; j++) begin
      e_wdata[(off + j) / 4][((off + j) % 4) * 8 +: 8] = d[j * 8 +: 8];
      if (j < n) e_wsel[(off + j) / 4][(off + j) % 4] = w;
    end
    n_acc = mis ? (SPLIT ? 2 : 0) : 1;
    if (mis && !SPLIT) e_err = 2'b01;
    s_beg[0] = t_acc + 1;
    for (int i = 0; i < 2; i++) begin
      if (i >= n_acc) break;
      if (i > 0) s_beg[i] = s_end[i - 1] + 1;
      acked[i] = kk[i] >= 0 && kk[i] <= TO - 1;
      s_end[i] = s_beg[i] + (acked[i] ? kk[i] : TO - 1);
      if (!acked[i]) begin
        e_err = 2'b10;
        n_acc = i + 1;
        break;
      end
    end
    t_rsp = (n_acc > 0) ? s_end[n_acc - 1] + 1 : t_acc + 1;
    lanes = {r1, r0};
    v = 0;
    for (int j = 0; j < n; j++) v[j * 8 +: 8] = lanes[(off + j) * 8 +: 8];
    if (!f[2] && v[n * 8 - 1]) for (int j = n; j < 4; j++) v[j * 8 +: 8] = 8'hFF;
    if (!w && e_err == 2'b00) e_rdata = v;
  endtask

  always @(negedge clk) if (chk_on) begin
    int a;
    a = -1;
    for (int i = 0; i < n_acc; i++) if (cyc >= s_beg[i] && cyc <= s_end[i]) a = i;
    check("bus_stb", bus_stb, a >= 0);
    check("req_ready", req_ready, !(cyc > t_acc && cyc <= t_rsp));
    check("rsp_valid", rsp_valid, cyc == t_rsp);
    if (a >= 0) begin
      check("bus_addr", bus_addr, e_addr[a]);
      check("bus_we", bus_we, e_we);
      check("bus_wsel", bus_wsel, e_wsel[a]);
      if (e_we) check("bus_wdata", bus_wdata, e_wdata[a]);
      seen_addr[a] = bus_addr; seen_wsel[a] = bus_wsel; seen_wdata[a] = bus_wdata;
    end
    if (cyc == t_rsp) begin
      check("rsp_rdata", rsp_rdata, e_rdata);
      check("rsp_err", rsp_err, e_err);
    end
    if (bus_stb) stb_cnt++;
    if (rsp_valid) begin
      seen_rdata = rsp_rdata; seen_err = rsp_err; seen_lat = cyc - t_acc;
    end
  end

  task automatic run_txn(input logic w, input logic [2:0] f, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] r0, input logic [31:0] r1, input int k0, input int k1, input bit hold);
    @(posedge clk); #2;
    req_valid = 1; req_write = w; req_fun3 = f; req_addr = a; req_wdata = d;
    bus_ack = 0;
    stb_cnt = 0; seen_lat = -1; seen_rdata = 'x; seen_err = 'x;
    seen_addr[0] = 'x; seen_addr[1] = 'x;
    t_acc = cyc;
    plan(w, f, a, d, r0, r1, k0, k1);
    while (cyc < t_rsp) begin
      @(posedge clk); #2;
      if (hold) begin
        req_write = nxt_w; req_fun3 = nxt_f; req_addr = nxt_a; req_wdata = nxt_d;
      end else req_valid = 0;
      bus_ack = 0; bus_rdata = 32'hDEADBEEF;
      for (int i = 0; i < n_acc; i++) if (acked[i] && cyc == s_end[i]) begin
        bus_ack = 1; bus_rdata = rd[i];
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n, input logic ack);
    repeat (n) begin
      @(posedge clk); #2;
      req_valid = 0; bus_ack = ack; bus_rdata = 32'h12345678;
    end
    bus_ack = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_bus_stb"}, bus_stb, 0);
    check({tag, "_bus_we"}, bus_we, 0);
    check({tag, "_bus_addr"}, bus_addr, 0);
    check({tag, "_bus_wsel"}, bus_wsel, 0);
    check({tag, "_bus_wdata"}, bus_wdata, 0);
  endtask

  initial begin
    int prev_rsp;
    repeat (3) @(posedge clk);
    #2 chk_reset_vals("reset");
    @(posedge clk); #2 reset = 0;
    chk_on = 1;
    idle(2, 0);
    run_txn(1, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0, 0, 0);
    check("sb_addr", seen_addr[0], 32'h1000);
    check("sb_wsel", seen_wsel[0], 4'b1000);
    check("sb_wdata", seen_wdata[0], 32'hA5000000);
    check("sb_lat", seen_lat, 2);
    check("sb_err", seen_err, 2'b00);
    run_txn(0, 3'b000, 32'h2002, 0, 32'h00F30000, 0, 1, 0, 0);
    check("lb_rdata", seen_rdata, 32'hFFFFFFF3);
    run_txn(0, 3'b100, 32'h2002, 0, 32'h00F30000, 0, 0, 0, 0);
    check("lbu_rdata", seen_rdata, 32'h000000F3);
    run_txn(0, 3'b101, 32'h2002, 0, 32'h80010000, 0, 2, 0, 0);
    check("lhu_rdata", seen_rdata, 32'h00008001);
    run_txn(0, 3'b001, 32'h2000, 0, 32'h12348001, 0, 0, 0, 0);
    run_txn(1, 3'b001, 32'h2002, 32'h0000BEEF, 0, 0, 2, 0, 0);
    run_txn(1, 3'b011, 32'h2004, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    idle(2, 1);
    run_txn(0, 3'b010, 32'h3000, 0, 0, 0, -1, 0, 0);
    check("to_stb_cycles", stb_cnt, TO);
    check("to_err", seen_err, 2'b10);
    check("to_rdata", seen_rdata, 0);
    check("to_lat", seen_lat, TO + 1);
    run_txn(0, 3'b010, 32'h3004, 0, 32'h11223344, 0, TO - 1, 0, 0);
    check("late_ack_err", seen_err, 2'b00);
    check("late_ack_rdata", seen_rdata, 32'h11223344);
    run_txn(0, 3'b010, 32'h4001, 0, 32'h44332211, 32'h88776655, 0, 1, 0);
    if (SPLIT) begin
      check("mis_addr0", seen_addr[0], 32'h4000);
      check("mis_addr1", seen_addr[1], 32'h4004);
      check("mis_rdata", seen_rdata, 32'h55443322);
      check("mis_lat", seen_lat, 4);
    end else begin
      check("mis_stb_cycles", stb_cnt, 0);
      check("mis_err", seen_err, 2'b01);
      check("mis_lat", seen_lat, 1);
    end
    run_txn(1, 3'b001, 32'h4003, 32'h0000ABCD, 0, 0, 1, 0, 0);
    run_txn(1, 3'b010, 32'h4002, 32'h01020304, 0, 0, 0, -1, 0);
    run_txn(0, 3'b110, 32'hFFFFFFFE, 0, 32'hA1B2C3D4, 32'h11223344, 0, 0, 0);
    @(posedge clk); #2;
    req_valid = 1; req_write = 0; req_fun3 = 3'b010; req_addr = 32'h5000;
    t_acc = cyc;
    plan(0, 3'b010, 32'h5000, 0, 0, 0, -1, 0);
    repeat (3) begin
      @(posedge clk); #2;
      req_valid = 0;
    end
    check("pre_reset_stb", bus_stb, 1);
    reset = 1;
    n_acc = 0; t_acc = -10; t_rsp = -10;
    #1 chk_reset_vals("midreset");
    @(posedge clk); #2 reset = 0;
    idle(3, 0);
    run_txn(0, 3'b010, 32'h6000, 0, 32'hA5A50001, 0, 1, 0, 0);
    check("post_reset_rdata", seen_rdata, 32'hA5A50001);
    nxt_w = 1; nxt_f = 3'b000; nxt_a = 32'h7001; nxt_d = 32'h00000077;
    run_txn(0, 3'b010, 32'h7000, 0, 32'h0BADF00D, 0, 5, 0, 1);
    check("stall_stb_cycles", stb_cnt, 6);
    check("stall_rdata", seen_rdata, 32'h0BADF00D);
    prev_rsp = t_rsp;
    run_txn(nxt_w, nxt_f, nxt_a, nxt_d, 0, 0, 0, 0, 0);
    check("stall_accept_cyc", t_acc, prev_rsp + 1);
    check("stall_sb_wdata", seen_wdata[0], 32'h00007700);
    check("stall_sb_wsel", seen_wsel[0], 4'b0010);
    idle(3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
